toggle_sched: RTL and testbench
===============================

TOGGLE_SCHED -- requirements
Module: toggle_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed 4 in this revision).
REQ-002 Parameter: HOLD, 3, grant length in clock cycles, legal range 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester request, level-sensitive.
REQ-006 din  input  4  per-requester data bit; din[i] belongs to req[i].
REQ-007 tgl  input  4  per-requester mode; tgl[i]=1 means invert q instead of loading din[i].
REQ-008 gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-009 q  output  1  shared register, written only on grant start.
REQ-010 busy  output  1  high while any gnt bit is high.
REQ-011 done  output  1  one-cycle pulse on grant release.
REQ-012 abort  output  1  one-cycle pulse, valid with done, set when release was early.

Function
REQ-013 FSM states IDLE and OWN; state, gnt, cnt, ptr (2-bit round-robin pointer), q, done and abort all registered.
REQ-014 IDLE, req==0: stay IDLE, gnt=0, q unchanged.
REQ-015 IDLE, req!=0: select first set req bit searching ptr, ptr+1, ... mod 4 (sel); at that edge gnt<=onehot(sel), cnt<=HOLD-1, state<=OWN.
REQ-016 Same start edge: q<=~q if tgl[sel], else q<=din[sel]; din/tgl sampled only at start edge.
REQ-017 Grant latency: req set before edge k -> gnt visible after edge k (one cycle).
REQ-018 OWN, req[sel]=1, cnt!=0: cnt<=cnt-1, gnt held.
REQ-019 OWN, req[sel]=1, cnt==0: release at that edge: gnt<=0, done<=1, abort<=0, ptr<=sel+1 mod 4, state<=IDLE.
REQ-020 Normal grant lasts exactly HOLD cycles; HOLD=1 gives single-cycle grant.
REQ-021 OWN, req[sel]=0 at any edge: early release at that edge: gnt<=0, done<=1, abort<=1, ptr<=sel+1 mod 4, state<=IDLE.
REQ-022 Early release takes priority over counting; cnt value ignored.
REQ-023 Other req bits changing during OWN: no effect on gnt, q or cnt.
REQ-024 done and abort high only in cycle after release edge; 0 otherwise.
REQ-025 Release cycle is IDLE: new grant at next edge at earliest; minimum one gnt=0 cycle between grants.
REQ-026 Round-robin: requester just released has lowest priority at next arbitration; with all 4 requesting continuously, order 0,1,2,3,0.
REQ-027 busy = |gnt (combinational from registered gnt).
REQ-028 At most one gnt bit high in every cycle.

Reset
REQ-029 rst_n low, any time: state=IDLE, gnt=0, cnt=0, ptr=0, q=0, done=0, abort=0, busy=0 immediately, without clk.
REQ-030 Reset mid-grant: grant dropped with no done/abort pulse; q returns to 0.
REQ-031 After rst_n rises, first arbitration at first clk edge with req!=0; ptr=0 so req[0] wins a tie.

Verification
REQ-032 Reset, req=4'b0010, din=4'b0010, tgl=0, held -> gnt=0010 for 3 cycles, q=1, then gnt=0 and done=1, abort=0 one cycle, next grant again to 1 after one idle cycle.
REQ-033 req=4'b1111 held, HOLD=3 -> grants 0001,0010,0100,1000,0001, each 3 cycles, one idle cycle between, done pulse after each.
REQ-034 req=4'b0100, tgl[2]=1, q=0, three grants -> q 1,0,1; din ignored.
REQ-035 req[0] granted, req[0] dropped after cycle 1 of grant -> gnt=0 next edge, done=1 and abort=1 same cycle, ptr=1.
REQ-036 HOLD=1, req=4'b0011 -> gnt alternates 0001,0000,0010,0000, done each release.
REQ-037 rst_n pulsed low mid-grant of requester 3 -> gnt, q, done, busy 0 asynchronously; after release, req=4'b1001 -> requester 0 granted.

Source files
------------

// File: rtl/toggle_sched_if.sv
// Bundle of the request/grant signals shared between toggle_sched and its user.
// The master side drives requests and per-requester data/mode bits; the slave
// (the scheduler) drives the grant vector, the shared q bit and the status pulses.
`timescale 1ns/1ps

interface toggle_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] tgl;
  logic [NREQ-1:0] gnt;
  logic            q;
  logic            busy;
  logic            done;
  logic            abort;

  modport master (
    output req, din, tgl,
    input  gnt, q, busy, done, abort
  );

  modport slave (
    input  req, din, tgl,
    output gnt, q, busy, done, abort
  );
endinterface

// File: rtl/toggle_sched.sv
// Round-robin grant scheduler with a shared one-bit register.
// A winning requester owns the grant for HOLD cycles (or less, if it drops its
// request). At the start of each grant the shared q bit is either loaded from
// the winner's din bit or inverted, depending on the winner's tgl bit.
// Release produces a one-cycle done pulse; abort accompanies it when the
// release was caused by the owner dropping its request.
`timescale 1ns/1ps

module toggle_sched #(
  parameter int NREQ = 4,
  parameter int HOLD = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  toggle_sched_if.slave bus
);

  localparam int          PW       = $clog2(NREQ);
  localparam logic [3:0]  CNT_INIT = 4'(HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [3:0]      r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_sel;
  logic            r_q;
  logic            r_done;
  logic            r_abort;

  state_t          w_state_next;
  logic [NREQ-1:0] w_gnt_next;
  logic [3:0]      w_cnt_next;
  logic [PW-1:0]   w_ptr_next;
  logic [PW-1:0]   w_sel_next;
  logic            w_q_next;
  logic            w_done_next;
  logic            w_abort_next;

  // Requests rotated so that bit 0 is the requester the pointer favours most.
  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_off;
  logic [PW-1:0]   w_sel;
  logic            w_any;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [PW-1:0] w_idx;
    assign w_idx      = r_ptr + PW'(gi);
    assign w_rot[gi]  = bus.req[w_idx];
  end

  assign w_any = |w_rot;

  // Lowest set bit of the rotated vector gives the offset from the pointer.
  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = PW'(k);
      end
    end
  end

  // Offset wraps naturally in PW bits, giving the modulo-NREQ search order.
  assign w_sel = r_ptr + w_off;

  // Next-state and registered-output logic for the IDLE/OWN controller.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_sel_next   = r_sel;
    w_q_next     = r_q;
    w_done_next  = 1'b0;
    w_abort_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_gnt_next = '0;
        if (w_any) begin
          w_state_next = OWN;
          w_gnt_next   = NREQ'(1) << w_sel;
          w_cnt_next   = CNT_INIT;
          w_sel_next   = w_sel;
          // din/tgl only matter here; they are ignored for the rest of the grant.
          w_q_next     = bus.tgl[w_sel] ? ~r_q : bus.din[w_sel];
        end
      end

      OWN: begin
        // Owner dropping its request wins over the hold counter.
        if (!bus.req[r_sel]) begin
          w_state_next = IDLE;
          w_gnt_next   = '0;
          w_done_next  = 1'b1;
          w_abort_next = 1'b1;
          w_ptr_next   = r_sel + PW'(1);
        end else if (r_cnt == 4'd0) begin
          w_state_next = IDLE;
          w_gnt_next   = '0;
          w_done_next  = 1'b1;
          w_ptr_next   = r_sel + PW'(1);
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  // State register; reset clears everything immediately, dropping any grant silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_cnt   <= 4'd0;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_q     <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_sel   <= w_sel_next;
      r_q     <= w_q_next;
      r_done  <= w_done_next;
      r_abort <= w_abort_next;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.q     = r_q;
  assign bus.busy  = |r_gnt;
  assign bus.done  = r_done;
  assign bus.abort = r_abort;

endmodule

// File: tb/tb_toggle_sched.sv
// Directed bench for toggle_sched: a table of per-cycle vectors for the HOLD=3
// instance, plus hand-written sequences for HOLD=1 and asynchronous reset.
`timescale 1ns/1ps

module tb_toggle_sched;

  logic clk;
  logic rst_n;

  toggle_sched_if #(.NREQ(4)) bus0 ();
  toggle_sched_if #(.NREQ(4)) bus1 ();

  toggle_sched #(.NREQ(4), .HOLD(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  toggle_sched #(.NREQ(4), .HOLD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] tgl;
    logic [3:0] gnt;
    logic       q;
    logic       done;
    logic       abort;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void add(bit rst, logic [3:0] req, logic [3:0] din, logic [3:0] tgl,
                              logic [3:0] gnt, logic q, logic done, logic abort);
    vec_t v;
    v.rst = rst; v.req = req; v.din = din; v.tgl = tgl;
    v.gnt = gnt; v.q = q; v.done = done; v.abort = abort;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Assert reset, confirm outputs clear without a clock edge, then release.
  task automatic do_reset();
    rst_n    = 1'b0;
    bus0.req = 4'b0; bus0.din = 4'b0; bus0.tgl = 4'b0;
    bus1.req = 4'b0; bus1.din = 4'b0; bus1.tgl = 4'b0;
    #1;
    chk("rst gnt",   bus0.gnt,         4'b0000);
    chk("rst q",     {3'b0, bus0.q},     4'b0);
    chk("rst done",  {3'b0, bus0.done},  4'b0);
    chk("rst abort", {3'b0, bus0.abort}, 4'b0);
    chk("rst busy",  {3'b0, bus0.busy},  4'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] dv;
  logic [3:0] h1_gnt [5];
  logic       h1_done[5];

  initial begin
    rst_n    = 1'b0;
    bus0.req = 4'b0; bus0.din = 4'b0; bus0.tgl = 4'b0;
    bus1.req = 4'b0; bus1.din = 4'b0; bus1.tgl = 4'b0;

    // Requester 1 alone, loading din: two full grants with one idle gap.
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0);

    // All four requesting: rotation 0,1,2,3,0; q follows din of each winner.
    dv = 4'b1010;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        add((g == 0) && (c == 0), 4'b1111, dv, 4'b0000, 4'b0001 << (g % 4), dv[g % 4], 0, 0);
      end
      add(0, 4'b1111, dv, 4'b0000, 4'b0000, dv[g % 4], 1, 0);
    end

    // Requester 2 in toggle mode: q goes 1,0,1 although din[2]=1.
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 3; c++) begin
        add((g == 0) && (c == 0), 4'b0100, 4'b0100, 4'b0100, 4'b0100, (g % 2) == 0, 0, 0);
      end
      add(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, (g % 2) == 0, 1, 1'b0);
    end

    // Early release of requester 0, pointer advances to 1, then other bits wiggle.
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 1, 1);
    add(0, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0);
    add(0, 4'b1010, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0);
    add(0, 4'b0110, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0);
    add(0, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 0, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus0.req = vecs[i].req;
      bus0.din = vecs[i].din;
      bus0.tgl = vecs[i].tgl;
      @(posedge clk);
      #1;
      $display("vec %0d req=%b din=%b tgl=%b -> gnt=%b q=%b busy=%b done=%b abort=%b",
               i, vecs[i].req, vecs[i].din, vecs[i].tgl,
               bus0.gnt, bus0.q, bus0.busy, bus0.done, bus0.abort);
      chk($sformatf("v%0d gnt", i),   bus0.gnt,            vecs[i].gnt);
      chk($sformatf("v%0d q", i),     {3'b0, bus0.q},      {3'b0, vecs[i].q});
      chk($sformatf("v%0d busy", i),  {3'b0, bus0.busy},   {3'b0, vecs[i].gnt != 4'b0});
      chk($sformatf("v%0d done", i),  {3'b0, bus0.done},   {3'b0, vecs[i].done});
      chk($sformatf("v%0d abort", i), {3'b0, bus0.abort},  {3'b0, vecs[i].abort});
    end

    // HOLD=1 instance: single-cycle grants alternating between 0 and 1.
    h1_gnt[0] = 4'b0001; h1_done[0] = 1'b0;
    h1_gnt[1] = 4'b0000; h1_done[1] = 1'b1;
    h1_gnt[2] = 4'b0010; h1_done[2] = 1'b0;
    h1_gnt[3] = 4'b0000; h1_done[3] = 1'b1;
    h1_gnt[4] = 4'b0001; h1_done[4] = 1'b0;
    do_reset();
    bus1.req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      $display("hold1 %0d gnt=%b done=%b abort=%b", i, bus1.gnt, bus1.done, bus1.abort);
      chk($sformatf("h1_%0d gnt", i),   bus1.gnt,           h1_gnt[i]);
      chk($sformatf("h1_%0d done", i),  {3'b0, bus1.done},  {3'b0, h1_done[i]});
      chk($sformatf("h1_%0d abort", i), {3'b0, bus1.abort}, 4'b0);
    end

    // Asynchronous reset in the middle of requester 3's grant.
    do_reset();
    bus0.req = 4'b1000;
    bus0.din = 4'b1000;
    @(posedge clk);
    #1;
    $display("arst start gnt=%b q=%b", bus0.gnt, bus0.q);
    chk("arst pre gnt", bus0.gnt,       4'b1000);
    chk("arst pre q",   {3'b0, bus0.q}, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    $display("arst low gnt=%b q=%b busy=%b done=%b", bus0.gnt, bus0.q, bus0.busy, bus0.done);
    chk("arst gnt",   bus0.gnt,           4'b0000);
    chk("arst q",     {3'b0, bus0.q},     4'b0);
    chk("arst busy",  {3'b0, bus0.busy},  4'b0);
    chk("arst done",  {3'b0, bus0.done},  4'b0);
    @(posedge clk);
    #1;
    chk("arst hold gnt",  bus0.gnt,           4'b0000);
    chk("arst hold done", {3'b0, bus0.done},  4'b0);
    chk("arst hold abort",{3'b0, bus0.abort}, 4'b0);
    rst_n    = 1'b1;
    bus0.req = 4'b1001;
    @(posedge clk);
    #1;
    $display("arst after gnt=%b q=%b done=%b", bus0.gnt, bus0.q, bus0.done);
    chk("arst post gnt",  bus0.gnt,           4'b0001);
    chk("arst post q",    {3'b0, bus0.q},     4'b0);
    chk("arst post done", {3'b0, bus0.done},  4'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
